// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAPT,
    PULSE
  } if_state_e;

  localparam logic [7:0]  BOOT_OFFSET_DEFAULT = 8'h80;
  localparam logic [31:0] PC_INCR             = 32'd4;

endpackage

// File: rtl/if_stage_in.sv
// Fetch front end: one outstanding req/gnt/rvalid transaction, captures the
// response into stable registers, then pulses out_en_o for the downstream latch.
module if_stage_in
  import if_fetch_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = 1,  // legal range 1..4
  parameter logic [7:0]  BOOT_OFFSET = BOOT_OFFSET_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        stall_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  output logic        out_en_o
);

  localparam logic [1:0] PULSE_LAST = 2'(PULSE_LEN - 1);

  // Handshake: instr_req_o/instr_addr_o rise together and stay constant until
  // the cycle instr_gnt_i is seen high; exactly one response (instr_rvalid_i)
  // is then accepted in WAIT. gnt outside REQ and rvalid outside WAIT are ignored.
  if_state_e   state_q;
  logic        booted_q;
  logic        discard_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] fetch_addr_d;
  logic [31:0] issued_pc_q;
  logic [1:0]  pulse_cnt_q;

  logic        go;
  logic [31:0] branch_tgt;
  logic [31:0] boot_tgt;
  logic        unused_addr_bits;

  assign go               = fetch_enable_i & ~stall_i;
  assign branch_tgt       = {branch_addr_i[31:2], 2'b00};
  assign boot_tgt         = {boot_addr_i[31:8], BOOT_OFFSET};
  assign unused_addr_bits = ^{boot_addr_i[7:0], branch_addr_i[1:0]};

  // In REQ a set discard_q marks a pending redirect: fetch_addr_q already holds
  // the target, so the grant of the held wrong-path request must not bump it.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (state_q == IDLE && go && !booted_q) begin
      fetch_addr_d = boot_tgt;
    end else if (state_q == REQ && instr_gnt_i && !discard_q) begin
      fetch_addr_d = fetch_addr_q + PC_INCR;
    end
    if (branch_i) begin
      fetch_addr_d = branch_tgt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      booted_q      <= 1'b0;
      discard_q     <= 1'b0;
      fetch_addr_q  <= '0;
      issued_pc_q   <= '0;
      pulse_cnt_q   <= '0;
      instr_req_o   <= 1'b0;
      instr_addr_o  <= '0;
      instr_rdata_o <= '0;
      instr_pc_o    <= '0;
      instr_err_o   <= 1'b0;
      out_en_o      <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q      <= REQ;
            booted_q     <= 1'b1;
            instr_req_o  <= 1'b1;
            instr_addr_o <= fetch_addr_d;
          end
        end
        REQ: begin
          if (branch_i) discard_q <= 1'b1;
          if (instr_gnt_i) begin
            state_q     <= WAIT;
            instr_req_o <= 1'b0;
            issued_pc_q <= instr_addr_o;
          end
        end
        WAIT: begin
          if (instr_rvalid_i) begin
            if (discard_q || branch_i) begin
              discard_q <= 1'b0;
              if (go) begin
                state_q      <= REQ;
                instr_req_o  <= 1'b1;
                instr_addr_o <= fetch_addr_d;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q       <= CAPT;
              instr_rdata_o <= instr_rdata_i;
              instr_err_o   <= instr_err_i;
              instr_pc_o    <= issued_pc_q;
            end
          end else if (branch_i) begin
            discard_q <= 1'b1;
          end
        end
        CAPT: begin
          if (branch_i) begin
            state_q      <= REQ;
            instr_req_o  <= 1'b1;
            instr_addr_o <= fetch_addr_d;
          end else begin
            state_q     <= PULSE;
            out_en_o    <= 1'b1;
            pulse_cnt_q <= '0;
          end
        end
        PULSE: begin
          if (branch_i) begin
            state_q      <= REQ;
            out_en_o     <= 1'b0;
            instr_req_o  <= 1'b1;
            instr_addr_o <= fetch_addr_d;
          end else if (pulse_cnt_q == PULSE_LAST) begin
            out_en_o <= 1'b0;
            if (go) begin
              state_q      <= REQ;
              instr_req_o  <= 1'b1;
              instr_addr_o <= fetch_addr_d;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stray grants/responses must leave the transaction registers untouched.
  a_gnt_ignored : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != REQ) |=> $stable(issued_pc_q));
  a_rvalid_ignored : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != WAIT) |=> ($stable(instr_rdata_o) && $stable(instr_err_o)));

endmodule

// File: tb/tb_if_stage_in.sv
// Directed bench for if_stage_in: PULSE_LEN=1 instance for most scenarios,
// PULSE_LEN=3 instance with its own handshake for the mid-pulse redirect.
module tb_if_stage_in;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        stall;
  logic [31:0] boot_addr;
  logic [31:0] branch_addr;
  logic [31:0] rdata;
  logic        err;

  logic        branch, gnt, rvalid;
  logic        req, err_o, en;
  logic [31:0] addr, rdata_o, pc_o;

  logic        branch3, gnt3, rvalid3;
  logic        req3, err3_o, en3;
  logic [31:0] addr3, rdata3_o, pc3_o;

  int n_cmp;
  int n_bad;

  if_stage_in u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_enable_i(fetch_en),
    .stall_i       (stall),
    .boot_addr_i   (boot_addr),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .instr_req_o   (req),
    .instr_addr_o  (addr),
    .instr_gnt_i   (gnt),
    .instr_rvalid_i(rvalid),
    .instr_rdata_i (rdata),
    .instr_err_i   (err),
    .instr_rdata_o (rdata_o),
    .instr_pc_o    (pc_o),
    .instr_err_o   (err_o),
    .out_en_o      (en)
  );

  if_stage_in #(.PULSE_LEN(3)) u_dut3 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_enable_i(fetch_en),
    .stall_i       (stall),
    .boot_addr_i   (boot_addr),
    .branch_i      (branch3),
    .branch_addr_i (branch_addr),
    .instr_req_o   (req3),
    .instr_addr_o  (addr3),
    .instr_gnt_i   (gnt3),
    .instr_rvalid_i(rvalid3),
    .instr_rdata_i (rdata),
    .instr_err_i   (err),
    .instr_rdata_o (rdata3_o),
    .instr_pc_o    (pc3_o),
    .instr_err_o   (err3_o),
    .out_en_o      (en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0;
    boot_addr = 32'h0000_1000; branch_addr = '0; rdata = '0; err = 1'b0;
    branch = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    branch3 = 1'b0; gnt3 = 1'b0; rvalid3 = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Boot fetch
    fetch_en = 1'b1; gnt = 1'b1;
    tick();
    chk("boot_req", 32'(req), 32'd1);
    chk("boot_addr", addr, 32'h0000_1080);
    chk("boot_addr3", addr3, 32'h0000_1080);
    tick();
    chk("boot_req_drop", 32'(req), 32'd0);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
    tick();
    rvalid = 1'b0;
    chk("boot_rdata", rdata_o, 32'h0000_0013);
    chk("boot_pc", pc_o, 32'h0000_1080);
    chk("boot_en_guard", 32'(en), 32'd0);
    tick();
    chk("boot_en_high", 32'(en), 32'd1);
    tick();
    chk("boot_en_low", 32'(en), 32'd0);
    chk("boot_next_req", 32'(req), 32'd1);
    chk("boot_next_addr", addr, 32'h0000_1084);

    // 2. Grant withheld for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_addr", addr, 32'h0000_1084);
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("hold_granted", 32'(req), 32'd0);
    tick();
    chk("hold_single_a", 32'(req), 32'd0);
    tick();
    chk("hold_single_b", 32'(req), 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_1234;
    tick();
    rvalid = 1'b0;
    chk("hold_pc", pc_o, 32'h0000_1084);
    tick();
    chk("hold_en", 32'(en), 32'd1);
    tick();
    chk("hold_next_addr", addr, 32'h0000_1088);

    // 3. Branch while waiting for the response
    gnt = 1'b1;
    tick();
    gnt = 1'b0; branch = 1'b1; branch_addr = 32'h0000_2002;
    tick();
    branch = 1'b0; rvalid = 1'b1; rdata = 32'h0000_DEAD;
    tick();
    rvalid = 1'b0;
    chk("br_wait_req", 32'(req), 32'd1);
    chk("br_wait_addr", addr, 32'h0000_2000);
    chk("br_wait_en", 32'(en), 32'd0);
    chk("br_wait_stale", rdata_o, 32'h0000_1234);
    tick();
    chk("br_wait_en_b", 32'(en), 32'd0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_2222;
    tick();
    rvalid = 1'b0;
    chk("br_wait_pc", pc_o, 32'h0000_2000);
    chk("br_wait_rdata", rdata_o, 32'h0000_2222);
    tick();
    chk("br_wait_en_high", 32'(en), 32'd1);
    tick();
    chk("br_wait_next", addr, 32'h0000_2004);

    // 5. Redirect to the top word, then wrap with a bus error
    branch = 1'b1; branch_addr = 32'hFFFF_FFFF;
    tick();
    branch = 1'b0;
    chk("wrap_held_addr", addr, 32'h0000_2004);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_5555;
    tick();
    rvalid = 1'b0;
    chk("wrap_req", 32'(req), 32'd1);
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; err = 1'b1; rdata = 32'h0000_BAD0;
    tick();
    rvalid = 1'b0; err = 1'b0;
    chk("wrap_err", 32'(err_o), 32'd1);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_en", 32'(en), 32'd1);
    tick();
    chk("wrap_next_addr", addr, 32'h0000_0000);
    chk("wrap_next_req", 32'(req), 32'd1);

    // 4. Redirect during a 3-cycle pulse
    gnt3 = 1'b1;
    tick();
    gnt3 = 1'b0; rvalid3 = 1'b1; rdata = 32'h0000_3333;
    tick();
    rvalid3 = 1'b0;
    tick();
    chk("p3_en_1", 32'(en3), 32'd1);
    tick();
    chk("p3_en_2", 32'(en3), 32'd1);
    branch3 = 1'b1; branch_addr = 32'h0000_4000;
    tick();
    branch3 = 1'b0;
    chk("p3_abort_en", 32'(en3), 32'd0);
    chk("p3_abort_req", 32'(req3), 32'd1);
    chk("p3_abort_addr", addr3, 32'h0000_4000);
    chk("p3_stale", rdata3_o, 32'h0000_3333);

    // 6. Asynchronous reset in WAIT, then boot re-sample
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(req), 32'd0);
    chk("ar_addr", addr, 32'd0);
    chk("ar_rdata", rdata_o, 32'd0);
    chk("ar_pc", pc_o, 32'd0);
    chk("ar_err", 32'(err_o), 32'd0);
    chk("ar_en3", 32'(en3), 32'd0);
    boot_addr = 32'h0000_5000;
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("reboot_req", 32'(req), 32'd1);
    chk("reboot_addr", addr, 32'h0000_5080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
